// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - core data-port to registered valid/ready bus bridge with stall and timeout
module mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        core_req_i,
  input  logic        core_wen_i,
  input  logic [31:0] core_waddr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [31:0] core_raddr_i,
  output logic [31:0] core_rdata_o,
  output logic        hold_flag_o,
  output logic        bus_valid_o,
  output logic        bus_wen_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ready_i,
  input  logic [31:0] bus_rdata_i,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  always_comb begin
    state_d    = state_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          state_d = REQ;
          wen_d   = core_wen_i;
          addr_d  = core_wen_i ? core_waddr_i : core_raddr_i;
          wdata_d = core_wdata_i;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      REQ: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (bus_ready_i) begin
          rdata_d = bus_rdata_i;
          state_d = DONE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rdata_d    = '0;
          err_addr_d = addr_q;
          err_d      = 1'b1;
          state_d    = DONE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        // The core still presents the old request here, so it is not sampled.
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign hold_flag_o  = rstn & ((state_q == IDLE) ? core_req_i : (state_q == REQ));
  assign bus_valid_o  = valid_q;
  assign bus_wen_o    = wen_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign core_rdata_o = rdata_q;
  assign err_o        = err_q;
  assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - vector table plus scoreboard bench for mem_bridge
module tb_mem_bridge;

  typedef struct {
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] slv_rdata;
    logic        b2b;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] err_addr;
  } exp_t;

  logic        clk, rstn;
  logic        req, req4, wen;
  logic [31:0] waddr, wdata, raddr;
  logic        ready;
  logic [31:0] bus_rdata;

  logic [31:0] rdata8, addr8, bwdata8, err_addr8;
  logic        hold8, valid8, bwen8, err8;
  logic [31:0] rdata4, addr4, bwdata4, err_addr4;
  logic        hold4, valid4, bwen4, err4;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  logic [31:0] last_err_addr = '0;
  logic        prev_valid = 1'b0;
  vec_t        vecs[6];

  mem_bridge #(.TIMEOUT_CYCLES(8)) dut8 (
    .clk(clk), .rstn(rstn), .core_req_i(req), .core_wen_i(wen),
    .core_waddr_i(waddr), .core_wdata_i(wdata), .core_raddr_i(raddr),
    .core_rdata_o(rdata8), .hold_flag_o(hold8), .bus_valid_o(valid8),
    .bus_wen_o(bwen8), .bus_addr_o(addr8), .bus_wdata_o(bwdata8),
    .bus_ready_i(ready), .bus_rdata_i(bus_rdata), .err_o(err8), .err_addr_o(err_addr8)
  );

  mem_bridge #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rstn(rstn), .core_req_i(req4), .core_wen_i(wen),
    .core_waddr_i(waddr), .core_wdata_i(wdata), .core_raddr_i(raddr),
    .core_rdata_o(rdata4), .hold_flag_o(hold4), .bus_valid_o(valid4),
    .bus_wen_o(bwen4), .bus_addr_o(addr4), .bus_wdata_o(bwdata4),
    .bus_ready_i(ready), .bus_rdata_i(bus_rdata), .err_o(err4), .err_addr_o(err_addr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completion monitor: a valid->idle transition with reset released marks the DONE cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !valid8) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_rdata", rdata8, e.rdata);
          chk("done_err", {31'd0, err8}, {31'd0, e.err});
          chk("done_err_addr", err_addr8, e.err_addr);
        end
      end
      prev_valid = valid8;
    end
  end

  task automatic do_txn(input vec_t v);
    logic [31:0] a;
    int          n;
    exp_t        e;
    a = v.wen ? v.waddr : v.raddr;
    n = (v.waits >= 8) ? 8 : v.waits + 1;
    @(posedge clk); #1;
    req = 1'b1; wen = v.wen; waddr = v.waddr; raddr = v.raddr; wdata = v.wdata;
    ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    if (v.exp_err) last_err_addr = a;
    e.err_addr = last_err_addr;
    sb.push_back(e);
    @(negedge clk);
    chk("idle_hold", {31'd0, hold8}, 32'd1);
    chk("idle_valid", {31'd0, valid8}, 32'd0);
    chk("idle_err", {31'd0, err8}, 32'd0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ready = (k == v.waits);
      bus_rdata = v.slv_rdata;
      @(negedge clk);
      chk("req_valid", {31'd0, valid8}, 32'd1);
      chk("req_hold", {31'd0, hold8}, 32'd1);
      chk("req_addr", addr8, a);
      chk("req_wen", {31'd0, bwen8}, {31'd0, v.wen});
      chk("req_wdata", bwdata8, v.wdata);
    end
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    chk("done_hold", {31'd0, hold8}, 32'd0);
    chk("done_valid", {31'd0, valid8}, 32'd0);
  endtask

  task automatic idle_gap();
    @(posedge clk); #1;
    req = 1'b0; ready = 1'b1; bus_rdata = 32'hCAFE_0000;
    @(negedge clk);
    chk("gap_hold", {31'd0, hold8}, 32'd0);
    chk("gap_valid", {31'd0, valid8}, 32'd0);
    chk("gap_err", {31'd0, err8}, 32'd0);
  endtask

  initial begin
    vec_t fin;
    //          wen   waddr          raddr          wdata          waits slv_rdata      b2b   exp_rdata      err
    vecs[0] = '{1'b0, 32'h7777_0000, 32'h1000_0004, 32'h0000_0000, 0,   32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0};
    vecs[1] = '{1'b1, 32'h2000_0010, 32'hFFFF_0000, 32'hDEAD_BEEF, 5,   32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0};
    vecs[2] = '{1'b0, 32'h7777_0004, 32'h3000_0020, 32'h1111_1111, 99,  32'h9999_9999, 1'b0, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 32'h7777_0008, 32'h1000_0008, 32'h2222_2222, 7,   32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    vecs[4] = '{1'b0, 32'h7777_000C, 32'h0000_0080, 32'h3333_3333, 0,   32'h0000_0011, 1'b0, 32'h0000_0011, 1'b0};
    vecs[5] = '{1'b0, 32'h7777_0010, 32'h0000_0100, 32'h4444_4444, 1,   32'h0000_0022, 1'b1, 32'h0000_0022, 1'b0};

    rstn = 1'b0; req = 1'b0; req4 = 1'b0; wen = 1'b0;
    waddr = '0; wdata = '0; raddr = '0; ready = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1 req = 1'b1;
    @(negedge clk);
    chk("rst_hold_forced", {31'd0, hold8}, 32'd0);
    chk("rst_valid", {31'd0, valid8}, 32'd0);
    chk("rst_wen", {31'd0, bwen8}, 32'd0);
    chk("rst_addr", addr8, 32'd0);
    chk("rst_wdata", bwdata8, 32'd0);
    chk("rst_rdata", rdata8, 32'd0);
    chk("rst_err", {31'd0, err8}, 32'd0);
    chk("rst_err_addr", err_addr8, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1; req = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].b2b) idle_gap();
      do_txn(vecs[i]);
    end
    idle_gap();

    // Ready on the exact timeout cycle of a TIMEOUT_CYCLES=4 bridge.
    @(posedge clk); #1;
    req4 = 1'b1; wen = 1'b0; raddr = 32'h4000_0040; ready = 1'b0;
    @(negedge clk);
    chk("t4_idle_hold", {31'd0, hold4}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      ready = (k == 3); bus_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("t4_req_valid", {31'd0, valid4}, 32'd1);
    end
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    chk("t4_done_rdata", rdata4, 32'h1234_5678);
    chk("t4_done_err", {31'd0, err4}, 32'd0);
    chk("t4_done_hold", {31'd0, hold4}, 32'd0);
    @(posedge clk); #1;
    req4 = 1'b0;
    @(negedge clk);
    chk("t4_after_err", {31'd0, err4}, 32'd0);
    chk("t4_after_valid", {31'd0, valid4}, 32'd0);

    // Asynchronous reset while a transaction is outstanding.
    @(posedge clk); #1;
    req = 1'b1; wen = 1'b0; raddr = 32'h5000_0050; ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_pre_valid", {31'd0, valid8}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid8}, 32'd0);
    chk("mid_rst_hold", {31'd0, hold8}, 32'd0);
    chk("mid_rst_err", {31'd0, err8}, 32'd0);
    chk("mid_rst_addr", addr8, 32'd0);
    req = 1'b0;
    @(negedge clk);
    chk("mid_rst_held_valid", {31'd0, valid8}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    last_err_addr = '0;
    idle_gap();
    fin = '{1'b0, 32'h7777_0014, 32'h6000_0060, 32'h5555_5555, 3, 32'h600D_0001, 1'b0, 32'h600D_0001, 1'b0};
    do_txn(fin);
    idle_gap();
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
